// File: rtl/ltl_symbol_feeder.sv
// ltl_symbol_feeder: buffers proposition events and frames each trace for the
// LTL automata cluster. Each trace gets an automata reset window, then one
// symbol per cycle qualified by sym_run, then a single trace_done pulse.
module ltl_symbol_feeder #(
  parameter int PROP_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_start,
  input  logic              trace_end,
  input  logic              ev_valid,
  input  logic [PROP_W-1:0] ev_props,
  output logic              ev_ready,
  output logic [7:0]        sym_out,
  output logic              sym_run,
  output logic              auto_reset,
  output logic              trace_done,
  output logic [15:0]       sym_count,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_AUTO,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_rst_cnt;
  logic              r_end_seen;

  logic [PROP_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [PROP_W-1:0] w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_ready;
  logic              w_start;

  logic [7:0]        r_sym_out;
  logic              r_sym_run;
  logic              r_auto_reset;
  logic              r_trace_done;
  logic [15:0]       r_sym_count;
  logic              r_busy;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_start = (r_state == S_IDLE) && trace_start;
  assign w_push  = ev_valid && w_ready;

  // Next-state, pop and ready decode; ready is combinational so a full FIFO
  // can still accept on a cycle that pops.
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (trace_start) w_next = S_RESET_AUTO;
      end
      S_RESET_AUTO: begin
        w_ready = !w_full;
        if (r_rst_cnt == '0)
          w_next = (r_end_seen || trace_end) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        w_pop   = !w_empty;
        w_ready = !w_full || w_pop;
        if (trace_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_pop = !w_empty;
        // Leaving on the first cycle with nothing to pop registers trace_done
        // directly after the final sym_run cycle.
        if (w_empty) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, reset-window counter and early trace_end latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rst_cnt  <= '0;
      r_end_seen <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_rst_cnt  <= CNT_INIT;
        r_end_seen <= 1'b0;
      end else if (r_state == S_RESET_AUTO) begin
        if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - 1'b1;
        if (trace_end) r_end_seen <= 1'b1;
      end
    end
  end

  // FIFO pointers; a new trace starts from an empty buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= ev_props;
  end

  // Registered symbol stream, framing outputs and saturating symbol count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sym_out    <= '0;
      r_sym_run    <= 1'b0;
      r_auto_reset <= 1'b0;
      r_trace_done <= 1'b0;
      r_sym_count  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_sym_run    <= w_pop;
      r_auto_reset <= (w_next == S_RESET_AUTO);
      r_busy       <= (w_next != S_IDLE);
      r_trace_done <= (r_state == S_DRAIN) && (w_next == S_IDLE);
      if (w_pop) r_sym_out <= 8'(w_head);
      if (w_start)
        r_sym_count <= '0;
      else if (w_pop && (r_sym_count != '1))
        r_sym_count <= r_sym_count + 1'b1;
    end
  end

  assign ev_ready   = w_ready;
  assign sym_out    = r_sym_out;
  assign sym_run    = r_sym_run;
  assign auto_reset = r_auto_reset;
  assign trace_done = r_trace_done;
  assign sym_count  = r_sym_count;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Testbench for ltl_symbol_feeder: directed vector table, hand sequences for
// multi-cycle corners and a randomized run against a queue-based trace model.
// Two instances share the stimulus (RST_CYCLES 2 and 8); sel picks the one
// being checked.
module tb_ltl_symbol_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, tend, valid;
  logic [3:0] props;

  logic       a_rdy, a_run, a_ar, a_done, a_busy;
  logic [7:0] a_sym;
  logic [15:0] a_cnt;
  logic       b_rdy, b_run, b_ar, b_done, b_busy;
  logic [7:0] b_sym;
  logic [15:0] b_cnt;

  int sel;
  logic       d_rdy, d_run, d_ar, d_done, d_busy;
  logic [7:0] d_sym;
  logic [15:0] d_cnt;

  assign d_rdy  = (sel == 1) ? b_rdy  : a_rdy;
  assign d_run  = (sel == 1) ? b_run  : a_run;
  assign d_ar   = (sel == 1) ? b_ar   : a_ar;
  assign d_done = (sel == 1) ? b_done : a_done;
  assign d_busy = (sel == 1) ? b_busy : a_busy;
  assign d_sym  = (sel == 1) ? b_sym  : a_sym;
  assign d_cnt  = (sel == 1) ? b_cnt  : a_cnt;

  ltl_symbol_feeder #(.PROP_W(4), .FIFO_DEPTH(8), .RST_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(rst), .trace_start(start), .trace_end(tend),
    .ev_valid(valid), .ev_props(props), .ev_ready(a_rdy), .sym_out(a_sym),
    .sym_run(a_run), .auto_reset(a_ar), .trace_done(a_done),
    .sym_count(a_cnt), .busy(a_busy));

  ltl_symbol_feeder #(.PROP_W(4), .FIFO_DEPTH(8), .RST_CYCLES(8)) u_dut8 (
    .clk(clk), .reset(rst), .trace_start(start), .trace_end(tend),
    .ev_valid(valid), .ev_props(props), .ev_ready(b_rdy), .sym_out(b_sym),
    .sym_run(b_run), .auto_reset(b_ar), .trace_done(b_done),
    .sym_count(b_cnt), .busy(b_busy));

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 auto-reset window, 2 stream, 3 drain.
  int m_phase, m_left, m_sym, m_run, m_done, m_count;
  bit m_end_seen;
  byte unsigned q[$];
  byte unsigned obs[$];
  int n_done;

  function automatic int m_rst_cycles();
    return (sel == 1) ? 8 : 2;
  endfunction

  function automatic int m_ready();
    if (m_phase == 1) return (q.size() < 8) ? 1 : 0;
    if (m_phase == 2) return (q.size() < 8 || q.size() > 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_left = 0; m_sym = 0; m_run = 0; m_done = 0; m_count = 0;
    m_end_seen = 1'b0;
    q.delete();
  endtask

  task automatic m_step();
    int pop_ok;
    int acc;
    pop_ok = ((m_phase == 2 || m_phase == 3) && q.size() > 0) ? 1 : 0;
    acc = (valid && m_ready() != 0) ? 1 : 0;
    m_done = 0;
    m_run = 0;
    if (pop_ok != 0) begin
      m_sym = int'(q.pop_front());
      m_run = 1;
      if (m_count < 65535) m_count++;
    end
    if (acc != 0) q.push_back({4'h0, props});
    case (m_phase)
      0: if (start) begin
           q.delete(); m_count = 0; m_left = m_rst_cycles() - 1;
           m_end_seen = 1'b0; m_phase = 1;
         end
      1: begin
           if (tend) m_end_seen = 1'b1;
           if (m_left == 0) m_phase = m_end_seen ? 3 : 2;
           else m_left--;
         end
      2: if (tend) m_phase = 3;
      default: if (pop_ok == 0) begin m_phase = 0; m_done = 1; end
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h sel=%0d t=%0t", nm, act, exp, sel, $time);
    end
  endtask

  task automatic check_model();
    chk("sym_out",    int'(d_sym),  m_sym);
    chk("sym_run",    int'(d_run),  m_run);
    chk("auto_reset", int'(d_ar),   (m_phase == 1) ? 1 : 0);
    chk("trace_done", int'(d_done), m_done);
    chk("sym_count",  int'(d_cnt),  m_count);
    chk("busy",       int'(d_busy), (m_phase != 0) ? 1 : 0);
    chk("ev_ready",   int'(d_rdy),  m_ready());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    @(negedge clk);
    check_model();
    if (d_run) obs.push_back(d_sym);
    if (d_done) n_done++;
  endtask

  task automatic drive(input logic st, input logic en, input logic vl, input logic [3:0] pr);
    start = st; tend = en; valid = vl; props = pr;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic switch_sel(input int s);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    sel = s;
    m_reset();
    cycle();
    cycle();
    rst = 1'b0;
    obs.delete();
    n_done = 0;
  endtask

  task automatic check_obs(input string nm, input byte unsigned exp[$]);
    chk({nm, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      chk({nm, "_sym"}, int'(obs[i]), int'(exp[i]));
  endtask

  typedef struct {
    logic st, en, vl;
    logic [3:0] pr;
    logic ar, run;
    logic [7:0] sym;
    logic done;
    logic [15:0] cnt;
    logic busy, rdy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    byte unsigned exp_q[$];
    int idx;
    int dut_acc;
    bit ended;

    // Basic trace (RST_CYCLES=2): inputs applied at edge i, outputs after it.
    //                st    en    vl    pr     ar    run   sym     done  cnt     busy  rdy
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 8'h03, 1'b0, 16'd1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'h0A, 1'b0, 16'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h0F, 1'b0, 16'd3, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h0F, 1'b1, 16'd3, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h0F, 1'b0, 16'd3, 1'b0, 1'b0};

    sel = 0;
    n_done = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    m_reset();
    @(negedge clk);
    chk("reset_sym_out", int'(d_sym), 0);
    chk("reset_sym_run", int'(d_run), 0);
    chk("reset_auto_reset", int'(d_ar), 0);
    chk("reset_trace_done", int'(d_done), 0);
    chk("reset_sym_count", int'(d_cnt), 0);
    chk("reset_busy", int'(d_busy), 0);
    chk("reset_ev_ready", int'(d_rdy), 0);
    cycle();
    rst = 1'b0;
    idle_cycles(2);

    // Basic trace from the vector table.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].st, tbl[i].en, tbl[i].vl, tbl[i].pr);
      cycle();
      chk("t1_auto_reset", int'(d_ar), int'(tbl[i].ar));
      chk("t1_sym_run", int'(d_run), int'(tbl[i].run));
      chk("t1_sym_out", int'(d_sym), int'(tbl[i].sym));
      chk("t1_trace_done", int'(d_done), int'(tbl[i].done));
      chk("t1_sym_count", int'(d_cnt), int'(tbl[i].cnt));
      chk("t1_busy", int'(d_busy), int'(tbl[i].busy));
      chk("t1_ev_ready", int'(d_rdy), int'(tbl[i].rdy));
    end

    // Simultaneous event and trace_end in STREAM.
    obs.delete(); n_done = 0;
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    idle_cycles(2);
    drive(1'b0, 1'b1, 1'b1, 4'h5); cycle();
    drive(1'b0, 1'b0, 1'b1, 4'h7);
    chk("t3_ready_after_end", int'(d_rdy), 0);
    for (int i = 0; i < 5; i++) cycle();
    exp_q = '{8'h05};
    check_obs("t3", exp_q);
    chk("t3_done_pulses", n_done, 1);
    chk("t3_sym_count", int'(d_cnt), 1);

    // trace_start ignored in STREAM, trace_end ignored in IDLE.
    obs.delete(); n_done = 0;
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    idle_cycles(2);
    drive(1'b0, 1'b0, 1'b1, 4'h1); cycle();
    drive(1'b0, 1'b0, 1'b1, 4'h2); cycle();
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    chk("t4_start_no_auto_reset", int'(d_ar), 0);
    chk("t4_start_no_clear", int'(d_cnt), 2);
    chk("t4_start_still_busy", int'(d_busy), 1);
    drive(1'b0, 1'b1, 1'b0, 4'h0); cycle();
    idle_cycles(4);
    chk("t4_done_pulses", n_done, 1);
    drive(1'b0, 1'b1, 1'b0, 4'h0); cycle();
    chk("t4_end_idle_busy", int'(d_busy), 0);
    chk("t4_end_idle_done", int'(d_done), 0);
    chk("t4_end_idle_count", int'(d_cnt), 2);
    idle_cycles(1);

    // Empty trace.
    obs.delete(); n_done = 0;
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    idle_cycles(2);
    drive(1'b0, 1'b1, 1'b0, 4'h0); cycle();
    idle_cycles(5);
    chk("t6_no_symbols", obs.size(), 0);
    chk("t6_done_pulses", n_done, 1);
    chk("t6_sym_count", int'(d_cnt), 0);

    // Backpressure with RST_CYCLES=8: 12 back-to-back events.
    switch_sel(1);
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    idx = 0; dut_acc = 0; ended = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      start = 1'b0;
      valid = (idx < 12);
      props = 4'(idx);
      tend = (idx == 12) && !ended;
      if (tend) ended = 1'b1;
      if (valid && d_rdy) begin idx++; dut_acc++; end
      cycle();
      if (c == 8) begin
        chk("t2_accepts_in_reset", dut_acc, 8);
        chk("t2_ready_on_first_pop", int'(d_rdy), 1);
      end
    end
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
    check_obs("t2", exp_q);
    chk("t2_sym_count", int'(d_cnt), 12);
    chk("t2_done_pulses", n_done, 1);

    // Asynchronous reset with 4 entries still buffered.
    obs.delete(); n_done = 0;
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    for (int c = 1; c <= 12; c++) begin
      drive(1'b0, 1'b0, (c <= 8), 4'(c));
      cycle();
    end
    chk("t5_pre_sym_count", int'(d_cnt), 4);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("t5_sym_out", int'(d_sym), 0);
    chk("t5_sym_run", int'(d_run), 0);
    chk("t5_auto_reset", int'(d_ar), 0);
    chk("t5_trace_done", int'(d_done), 0);
    chk("t5_sym_count", int'(d_cnt), 0);
    chk("t5_busy", int'(d_busy), 0);
    chk("t5_ev_ready", int'(d_rdy), 0);
    m_reset();
    cycle();
    rst = 1'b0;
    idle_cycles(2);
    chk("t5_no_done_after_reset", n_done, 0);
    obs.delete();
    drive(1'b1, 1'b0, 1'b0, 4'h0); cycle();
    drive(1'b0, 1'b0, 1'b1, 4'hC); cycle();
    drive(1'b0, 1'b0, 1'b1, 4'hD); cycle();
    drive(1'b0, 1'b1, 1'b0, 4'h0); cycle();
    idle_cycles(12);
    exp_q = '{8'h0C, 8'h0D};
    check_obs("t5_new_trace", exp_q);
    chk("t5_new_done_pulses", n_done, 1);

    // Randomized traffic on both configurations against the model.
    for (int s = 0; s < 2; s++) begin
      switch_sel(s);
      for (int i = 0; i < 1500; i++) begin
        rst   = ($urandom_range(0, 399) == 0);
        start = ($urandom_range(0, 9) == 0);
        tend  = ($urandom_range(0, 11) == 0);
        valid = ($urandom_range(0, 1) == 1);
        props = 4'($urandom);
        cycle();
      end
      rst = 1'b0;
      idle_cycles(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
